ddr_app_arbiter: RTL

DDR_APP_ARBITER -- requirements
Module: ddr_app_arbiter

---
 rtl/ddr_arb_pkg.sv | 21 ++
 rtl/ddr_app_arbiter_if.sv | 26 ++
 rtl/ddr_arb_tag_fifo.sv | 52 +++++
 rtl/ddr_app_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared constants, FSM state type and width helpers for the DDR app-port arbiter.
package ddr_arb_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {IDLE, WR, RD} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Index width that stays at least one bit wide for single-entry cases.
    function automatic int tag_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_app_arbiter_if.sv
// DDR controller application-side command/write/read-return bundle.
interface ddr_app_arbiter_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 64
);
    logic                  o_ddr_app_en;
    logic [2:0]            o_ddr_cmd;
    logic [ADDR_WIDTH-1:0] o_ddr_addr;
    logic                  i_ddr_app_rdy;
    logic [DATA_WIDTH-1:0] o_ddr_wr_data;
    logic                  o_ddr_wr_en;
    logic                  o_ddr_wr_end;
    logic                  i_ddr_wr_rdy;
    logic [DATA_WIDTH-1:0] i_ddr_rd_data;
    logic                  i_ddr_rd_data_valid;

    modport master (
        output o_ddr_app_en, o_ddr_cmd, o_ddr_addr, o_ddr_wr_data, o_ddr_wr_en, o_ddr_wr_end,
        input  i_ddr_app_rdy, i_ddr_wr_rdy, i_ddr_rd_data, i_ddr_rd_data_valid
    );

    modport slave (
        input  o_ddr_app_en, o_ddr_cmd, o_ddr_addr, o_ddr_wr_data, o_ddr_wr_en, o_ddr_wr_end,
        output i_ddr_app_rdy, i_ddr_wr_rdy, i_ddr_rd_data, i_ddr_rd_data_valid
    );
endinterface

// File: rtl/ddr_arb_tag_fifo.sv
// Synchronous FIFO of port tags for reads accepted by the DDR and awaiting data.
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 1,
    parameter int CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = tag_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop)  rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/ddr_app_arbiter.sv
// Round-robin arbiter of NUM_PORTS user read/write ports onto one DDR app interface.
// Optional per-port acked-transaction counters when DDR_ARB_PERF_EN is defined.
module ddr_app_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_WIDTH      = 28,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            i_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_wr_data,
    output logic [NUM_PORTS-1:0]            o_wr_ack,
    input  logic [NUM_PORTS-1:0]            i_rd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_PORTS-1:0]            o_rd_ack,
    output logic [DATA_WIDTH-1:0]           o_rd_data,
    output logic [NUM_PORTS-1:0]            o_rd_valid,
    output logic                            o_err,
`ifdef DDR_ARB_PERF_EN
    output logic [NUM_PORTS*32-1:0]         o_grant_cnt,
`endif
    ddr_app_arbiter_if.master               ddr
);
    localparam int TW = tag_w(NUM_PORTS);
    localparam int OW = clog2(MAX_OUTSTANDING + 1);

    state_e                state_q, state_d;
    logic [TW-1:0]         port_q, port_d, ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cmd_done_q, cmd_done_d, dat_done_q, dat_done_d;
    logic                  cmd_ok, dat_ok, found, push, pop;
    int                    idx;
    logic                  fifo_full, fifo_empty;
    logic [TW-1:0]         fifo_tag;
    logic [OW-1:0]         outstanding;
    logic [NUM_PORTS-1:0]  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  err_q;

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cmd_done_d = cmd_done_q;
        dat_done_d = dat_done_q;
        o_wr_ack   = '0;
        o_rd_ack   = '0;
        push       = 1'b0;
        found      = 1'b0;
        idx        = 0;
        cmd_ok     = cmd_done_q | ddr.i_ddr_app_rdy;
        dat_ok     = dat_done_q | ddr.i_ddr_wr_rdy;
        unique case (state_q)
            IDLE: begin
                // Search from the port after the last grant; write wins within a port.
                for (int i = 0; i < NUM_PORTS; i++) begin
                    idx = (int'(ptr_q) + i) % NUM_PORTS;
                    if (!found && (i_wr[idx] || (i_rd[idx] && !fifo_full))) begin
                        found      = 1'b1;
                        port_d     = TW'(idx);
                        ptr_d      = TW'((idx + 1) % NUM_PORTS);
                        cmd_done_d = 1'b0;
                        dat_done_d = 1'b0;
                        if (i_wr[idx]) begin
                            state_d = WR;
                            addr_d  = i_wr_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                            wdata_d = i_wr_data[idx*DATA_WIDTH +: DATA_WIDTH];
                        end else begin
                            state_d = RD;
                            addr_d  = i_rd_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                    end
                end
            end
            WR: begin
                cmd_done_d = cmd_ok;
                dat_done_d = dat_ok;
                if (cmd_ok && dat_ok) begin
                    o_wr_ack[port_q] = 1'b1;
                    state_d          = IDLE;
                end
            end
            RD: begin
                if (ddr.i_ddr_app_rdy) begin
                    o_rd_ack[port_q] = 1'b1;
                    push             = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            port_q     <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cmd_done_q <= 1'b0;
            dat_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cmd_done_q <= cmd_done_d;
            dat_done_q <= dat_done_d;
        end
    end

    assign ddr.o_ddr_app_en  = (state_q == RD) || ((state_q == WR) && !cmd_done_q);
    assign ddr.o_ddr_cmd     = (state_q == RD) ? CMD_RD : CMD_WR;
    assign ddr.o_ddr_addr    = addr_q;
    assign ddr.o_ddr_wr_data = wdata_q;
    assign ddr.o_ddr_wr_en   = (state_q == WR) && !dat_done_q;
    assign ddr.o_ddr_wr_end  = (state_q == WR) && !dat_done_q;

    ddr_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .W(TW), .CW(OW)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .din_i   (port_q),
        .pop_i   (pop),
        .dout_o  (fifo_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding)
    );

    // Returned data with no tag to attribute it to is discarded and flagged.
    assign pop = ddr.i_ddr_rd_data_valid && !fifo_empty;

    always_comb begin
        rd_valid_d = '0;
        if (pop) rd_valid_d[fifo_tag] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            if (pop) rd_data_q <= ddr.i_ddr_rd_data;
            if (ddr.i_ddr_rd_data_valid && outstanding == '0) err_q <= 1'b1;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;
    assign o_err      = err_q;

`ifdef DDR_ARB_PERF_EN
    logic [NUM_PORTS-1:0][31:0] gcnt_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_perf
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                gcnt_q[p] <= '0;
            else if ((o_wr_ack[p] || o_rd_ack[p]) && gcnt_q[p] != '1)
                gcnt_q[p] <= gcnt_q[p] + 32'd1;
        end
    end

    assign o_grant_cnt = gcnt_q;
`endif
endmodule
